pe_result_collector: RTL
========================

PE_RESULT_COLLECTOR -- requirements
Module: pe_result_collector

Interface
REQ-001 Parameter COL, default 16: PE columns per row, one result per column.
REQ-002 Parameter ROW, default 2: PE rows per capture.
REQ-003 Parameter DW, default 16: result width in bits (Q7.9 fixed point, passed through unmodified).
REQ-004 Parameter DEPTH, default 2: capture entries buffered; each entry holds ROW rows plus a tag.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 pe_array_out  input  ROW*COL*DW  packed [ROW-1:0][COL-1:0][DW-1:0] array results.
REQ-009 rounder_valid  input  1  single-cycle qualifier: pe_array_out and round_number are valid this cycle.
REQ-010 round_number  input  4  accumulation-slot tag accompanying the results.
REQ-011 out_valid  output  1  a result row is presented.
REQ-012 out_ready  input  1  downstream accepts the row this cycle.
REQ-013 out_data  output  COL*DW  one row; column n at bits [n*DW +: DW].
REQ-014 out_row  output  1  row index m of the presented row (clog2(ROW) bits in general).
REQ-015 out_round  output  4  tag of the entry being drained.
REQ-016 out_last  output  1  the presented row is row ROW-1 of its entry.
REQ-017 fill_level  output  clog2(DEPTH+1)  number of occupied entries.
REQ-018 overflow  output  1  sticky flag: a capture was dropped.
REQ-019 clear_overflow  input  1  synchronous clear for overflow.

Function
REQ-020 A capture is a rising clk edge with rounder_valid=1 and the buffer not full, or full with a pop on the same edge; it writes all ROW*COL results and round_number into the tail entry.
REQ-021 A captured entry is visible on out_valid in the cycle after the capture edge; capture-to-out_valid latency is exactly 1 cycle.
REQ-022 out_valid SHALL be 1 exactly when fill_level != 0.
REQ-023 A beat transfers on an edge with out_valid=1 and out_ready=1.
REQ-024 Row order within an entry is row 0 first, then ascending; entries drain in FIFO order.
REQ-025 A transfer of a row other than the last increments the row counter; a transfer with out_last=1 pops the head entry and resets the row counter to 0.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_row, out_round and out_last SHALL hold their values.
REQ-027 While out_valid=0, out_data, out_row, out_round and out_last SHALL be 0.
REQ-028 Simultaneous capture and pop on one edge leaves fill_level unchanged, including when full.
REQ-029 rounder_valid while full with no pop on that edge drops the capture, leaves the buffer contents unchanged, and sets overflow on that edge.
REQ-030 clear_overflow=1 clears overflow on the next edge; a simultaneous set wins.
REQ-031 Read and write pointers wrap modulo DEPTH.
REQ-032 Sustained throughput is one capture per ROW cycles with out_ready held at 1.

Reset
REQ-033 Reset asserted asynchronously forces, without a clock edge: fill_level=0, pointers=0, row counter=0, overflow=0, out_valid=0 and all data outputs 0.
REQ-034 Assertion of rst mid-drain discards all buffered entries; after deassertion the first beat comes from the next capture.
REQ-035 Buffer storage contents need no reset; only control state is reset.

Verification
REQ-036 Single capture: row0 columns = 0x0100+n, row1 columns = 0x0200+n, round_number=5, out_ready=1 -> out_valid in the next cycle; beat1: out_row=0, out_last=0, out_round=5; beat2: out_row=1, out_last=1; then out_valid=0.
REQ-037 Backpressure: capture, then hold out_ready=0 for 4 cycles -> out_data stays equal to row 0 and fill_level stays 1; releasing out_ready gives 2 beats.
REQ-038 Overflow: 3 captures with tags 1, 2, 3 and out_ready=0 -> fill_level=2 and overflow=1; draining yields tags 1 then 2 only; clear_overflow then gives overflow=0.
REQ-039 Full plus simultaneous: fill_level=2, rounder_valid asserted on the edge where the row-1 beat of the head transfers -> capture accepted, fill_level stays 2, overflow stays 0.
REQ-040 Streaming: rounder_valid every 2nd cycle for 8 captures, out_ready=1 -> 16 beats in order, no overflow, pointers wrap correctly.
REQ-041 Reset mid-drain: assert rst after the row-0 beat -> out_valid=0 and fill_level=0 immediately; no stale beat after deassertion.

Source files
------------

// File: rtl/pe_result_collector.sv
// rtl/pe_result_collector.sv - buffers PE array captures and drains them one row per beat
// Each entry holds ROW rows of COL results plus a 4-bit round tag.
module pe_result_collector #(
  parameter int COL   = 16,
  parameter int ROW   = 2,
  parameter int DW    = 16,
  parameter int DEPTH = 2,
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ROW-1:0][COL-1:0][DW-1:0] pe_array_out,
  input  logic                           rounder_valid,
  input  logic [3:0]                     round_number,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COL*DW-1:0]              out_data,
  output logic [RW-1:0]                  out_row,
  output logic [3:0]                     out_round,
  output logic                           out_last,
  output logic [FW-1:0]                  fill_level,
  output logic                           overflow,
  input  logic                           clear_overflow
);

  logic [ROW*COL*DW-1:0] r_mem [DEPTH];
  logic [3:0]            r_tag [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [FW-1:0]         r_fill;
  logic [RW-1:0]         r_row;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_nonempty;
  logic                  w_row_last;
  logic                  w_xfer;
  logic                  w_pop;
  logic                  w_push;
  logic [ROW*COL*DW-1:0] w_head;
  logic [COL*DW-1:0]     w_row_data;

  assign w_full     = (r_fill == FW'(DEPTH));
  assign w_nonempty = (r_fill != '0);
  assign w_row_last = (r_row == RW'(ROW - 1));
  assign w_xfer     = w_nonempty && out_ready;
  assign w_pop      = w_xfer && w_row_last;
  // When full, a pop on the same edge frees the head slot, which is also the tail slot.
  assign w_push     = rounder_valid && (!w_full || w_pop);
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pe_array_out;
      r_tag[r_wr_ptr] <= round_number;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_row      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_xfer) begin
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      // A dropped capture on the same edge as a clear keeps the flag set.
      if (rounder_valid && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    w_row_data = '0;
    for (int m = 0; m < ROW; m++) begin
      if (r_row == RW'(m)) begin
        w_row_data = w_head[m*COL*DW +: COL*DW];
      end
    end
  end

  // Data outputs are forced to zero whenever nothing is presented.
  assign out_valid  = w_nonempty;
  assign out_data   = w_nonempty ? w_row_data : '0;
  assign out_row    = w_nonempty ? r_row : '0;
  assign out_round  = w_nonempty ? r_tag[r_rd_ptr] : 4'd0;
  assign out_last   = w_nonempty && w_row_last;
  assign fill_level = r_fill;
  assign overflow   = r_overflow;

endmodule
